datapath_ctrl: RTL and testbench

- Multi-cycle control unit that sequences the 16-bit datapath.
- Fetches each instruction from an instruction-memory port with a req/valid handshake, then decodes it.
- Drives every datapath control input: register addresses, immediate, alu_sel, imm_sel, rf_write, mem_write, mem_sel.
- Updates the PC using the datapath zero/positive flags for conditional branches.

---
 rtl/ctrl_pkg.sv | 55 +++++
 rtl/instr_decode.sv | 47 ++++
 rtl/datapath_ctrl.sv | 177 +++++++++++++++++
 tb/tb_datapath_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the datapath control unit: FSM states,
// opcode encodings, instruction field positions and the decoded control bundle.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    BR_JMP = 2'd0,
    BR_Z   = 2'd1,
    BR_P   = 2'd2,
    BR_NONE = 2'd3
  } br_t;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_MOVI = 5'b10110;
  localparam logic [4:0] OP_LD   = 5'b10000;
  localparam logic [4:0] OP_ST   = 5'b10001;
  localparam logic [4:0] OP_JMP  = 5'b11000;
  localparam logic [4:0] OP_BZ   = 5'b11001;
  localparam logic [4:0] OP_BP   = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [3:0] ALU_PASS_B = 4'b1011;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int RD_MSB  = 10;
  localparam int RD_LSB  = 8;
  localparam int RS_MSB  = 7;
  localparam int RS_LSB  = 5;
  localparam int RT_MSB  = 4;
  localparam int RT_LSB  = 2;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef struct packed {
    logic       is_alu;
    logic       is_movi;
    logic       is_ld;
    logic       is_st;
    logic       is_branch;
    br_t        br_type;
    logic       is_halt;
    logic       illegal;
    logic [3:0] alu_sel;
  } ctrl_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: turns the instruction opcode field into the
// control bundle consumed by the sequencing FSM.
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output ctrl_t      ctrl
);

  // opcode classification; undefined encodings flagged illegal and act as NOP
  always_comb begin
    ctrl         = '0;
    ctrl.br_type = BR_NONE;
    if (opcode[4] == 1'b0) begin
      if (opcode != OP_NOP) begin
        ctrl.is_alu  = 1'b1;
        ctrl.alu_sel = opcode[3:0];
      end else begin
        ctrl.is_alu  = 1'b0;
      end
    end else begin
      case (opcode)
        OP_MOVI: begin
          ctrl.is_movi = 1'b1;
          ctrl.alu_sel = ALU_PASS_B;
        end
        OP_LD:   ctrl.is_ld = 1'b1;
        OP_ST:   ctrl.is_st = 1'b1;
        OP_JMP: begin
          ctrl.is_branch = 1'b1;
          ctrl.br_type   = BR_JMP;
        end
        OP_BZ: begin
          ctrl.is_branch = 1'b1;
          ctrl.br_type   = BR_Z;
        end
        OP_BP: begin
          ctrl.is_branch = 1'b1;
          ctrl.br_type   = BR_P;
        end
        OP_HALT: ctrl.is_halt = 1'b1;
        default: ctrl.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle sequencer for the 16-bit datapath: fetch over a req/valid port,
// decode, execute branches, and issue one-cycle writeback enables.
module datapath_ctrl
  import ctrl_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              imem_valid,
  output logic [2:0]        rs_addr,
  output logic [2:0]        rt_addr,
  output logic [2:0]        rd_addr,
  output logic [DATA_W-1:0] imm_data,
  output logic [3:0]        alu_sel,
  output logic              imm_sel,
  output logic              rf_write,
  output logic              mem_write,
  output logic              mem_sel,
  input  logic              zero_flag,
  input  logic              pos_flag,
  output logic              halted,
  output logic              illegal_op
);

  localparam logic [PC_W-1:0] PC_INIT = PC_W'(RESET_PC);

  state_t            state, next_state;
  logic [PC_W-1:0]   pc, next_pc;
  logic [DATA_W-1:0] ir, next_ir;
  logic              zf_q, pf_q, next_zf, next_pf;
  logic              take_branch;
  ctrl_t             ctrl;

  instr_decode u_decode (
    .opcode (ir[OPC_MSB:OPC_LSB]),
    .ctrl   (ctrl)
  );

  // state, PC, IR and flag latches
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      pc    <= PC_INIT;
      ir    <= '0;
      zf_q  <= 1'b0;
      pf_q  <= 1'b0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      ir    <= next_ir;
      zf_q  <= next_zf;
      pf_q  <= next_pf;
    end
  end

  // branch condition from the latched flags
  always_comb begin
    case (ctrl.br_type)
      BR_JMP:  take_branch = 1'b1;
      BR_Z:    take_branch = zf_q;
      BR_P:    take_branch = pf_q;
      default: take_branch = 1'b0;
    endcase
  end

  // next-state, PC and flag update
  always_comb begin
    next_state = state;
    next_pc    = pc;
    next_ir    = ir;
    next_zf    = zf_q;
    next_pf    = pf_q;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          next_state = ST_FETCH;
          next_pc    = PC_INIT;
          next_zf    = 1'b0;
          next_pf    = 1'b0;
        end else begin
          next_state = state;
        end
      end
      ST_FETCH: begin
        if (imem_valid) begin
          next_ir    = imem_data;
          next_pc    = pc + PC_W'(1);
          next_state = ST_DECODE;
        end else begin
          next_state = ST_FETCH;
        end
      end
      ST_DECODE: next_state = ST_EXECUTE;
      ST_EXECUTE: begin
        if (ctrl.is_halt) begin
          next_state = ST_HALT;
        end else if (ctrl.is_branch) begin
          next_state = ST_FETCH;
          if (take_branch) begin
            next_pc = PC_W'(ir[IMM_MSB:IMM_LSB]);
          end else begin
            next_pc = pc;
          end
        end else begin
          next_state = ST_WRITEBACK;
        end
      end
      ST_WRITEBACK: begin
        next_state = ST_FETCH;
        if (ctrl.is_alu || ctrl.is_movi) begin
          next_zf = zero_flag;
          next_pf = pos_flag;
        end else begin
          next_zf = zf_q;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // outputs decoded from state and IR only; everything idles at zero
  always_comb begin
    imem_req   = 1'b0;
    imem_addr  = '0;
    rs_addr    = 3'd0;
    rt_addr    = 3'd0;
    rd_addr    = 3'd0;
    imm_data   = '0;
    alu_sel    = 4'd0;
    imm_sel    = 1'b0;
    rf_write   = 1'b0;
    mem_write  = 1'b0;
    mem_sel    = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req  = 1'b1;
        imem_addr = pc;
      end
      ST_DECODE, ST_EXECUTE, ST_WRITEBACK: begin
        imem_addr = pc;
        rd_addr   = ir[RD_MSB:RD_LSB];
        rt_addr   = ir[RT_MSB:RT_LSB];
        rs_addr   = ctrl.is_movi ? 3'd0 : ir[RS_MSB:RS_LSB];
        imm_data  = {{(DATA_W-8){1'b0}}, ir[IMM_MSB:IMM_LSB]};
        imm_sel   = ctrl.is_movi;
        if (state == ST_DECODE) begin
          illegal_op = ctrl.illegal;
        end else begin
          // ALU select held through writeback so the result stays valid
          alu_sel = ctrl.alu_sel;
        end
        if (state == ST_WRITEBACK) begin
          rf_write  = ctrl.is_alu || ctrl.is_movi || ctrl.is_ld;
          mem_write = ctrl.is_st;
          mem_sel   = ctrl.is_ld;
        end else begin
          rf_write  = 1'b0;
        end
      end
      ST_HALT: begin
        halted    = 1'b1;
        imem_addr = pc;
      end
      default: imem_req = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed-vector bench for datapath_ctrl: steps the FSM cycle by cycle and
// compares outputs against hand-computed values.
module tb_datapath_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [2:0]  rs_addr, rt_addr, rd_addr;
  logic [15:0] imm_data;
  logic [3:0]  alu_sel;
  logic        imm_sel, rf_write, mem_write, mem_sel;
  logic        zero_flag, pos_flag;
  logic        halted, illegal_op;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_pc;

  datapath_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .imem_valid (imem_valid),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rd_addr    (rd_addr),
    .imm_data   (imm_data),
    .alu_sel    (alu_sel),
    .imm_sel    (imm_sel),
    .rf_write   (rf_write),
    .mem_write  (mem_write),
    .mem_sel    (mem_sel),
    .zero_flag  (zero_flag),
    .pos_flag   (pos_flag),
    .halted     (halted),
    .illegal_op (illegal_op)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // present instr after nwait stalled cycles; returns in DECODE
  task automatic fetch(input logic [15:0] instr, input int nwait);
    check("fetch_req", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
    for (int i = 0; i < nwait; i++) begin
      imem_valid = 1'b0;
      tick();
      check("stall_req", {31'd0, imem_req}, 32'd1);
      check("stall_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
      check("stall_en", {29'd0, rf_write, mem_write, mem_sel}, 32'd0);
    end
    imem_valid = 1'b1;
    imem_data  = instr;
    tick();
    imem_valid = 1'b0;
    imem_data  = 16'h0000;
    exp_pc     = exp_pc + 8'd1;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; imem_valid = 1'b0; imem_data = 16'h0000;
    zero_flag = 1'b0; pos_flag = 1'b0; exp_pc = 8'h00;
    tick(); tick();
    check("rst_req", {31'd0, imem_req}, 32'd1 - 32'd1);
    check("rst_outs", {imem_addr, halted, illegal_op, rf_write, mem_write, mem_sel, imm_sel, alu_sel}, 32'd0);
    reset = 1'b1;
    tick(); tick();
    check("idle_req", {31'd0, imem_req}, 32'd0);

    // MOVI R7,#8 after three withheld fetch cycles
    start = 1'b1; tick(); start = 1'b0;
    fetch(16'hB708, 3);
    check("movi_rd", {29'd0, rd_addr}, 32'd7);
    check("movi_imm", {16'd0, imm_data}, 32'd8);
    check("movi_immsel", {31'd0, imm_sel}, 32'd1);
    check("movi_rs", {29'd0, rs_addr}, 32'd0);
    check("movi_de_wr", {31'd0, rf_write}, 32'd0);
    check("movi_ill", {31'd0, illegal_op}, 32'd0);
    tick();
    check("movi_alu", {28'd0, alu_sel}, 32'hB);
    check("movi_ex_wr", {31'd0, rf_write}, 32'd0);
    tick();
    check("movi_wb_wr", {31'd0, rf_write}, 32'd1);
    check("movi_wb_msel", {31'd0, mem_sel}, 32'd0);
    tick();
    check("movi_post_wr", {31'd0, rf_write}, 32'd0);
    check("next_addr", {24'd0, imem_addr}, 32'd1);

    // MOVI R1,#0 with zero flag set, then taken BZ 0x40
    fetch(16'hB100, 0);
    tick(); tick(); zero_flag = 1'b1;
    tick(); zero_flag = 1'b0;
    fetch(16'hC840, 0);
    check("bz_de_wr", {31'd0, rf_write}, 32'd0);
    tick();
    check("bz_ex_wr", {31'd0, rf_write}, 32'd0);
    tick();
    check("bz_taken", {24'd0, imem_addr}, 32'h40);
    check("bz_post_wr", {31'd0, rf_write}, 32'd0);
    exp_pc = 8'h40;

    // MOVI R1,#1 clears zero flag, BZ falls through
    fetch(16'hB101, 0);
    tick(); tick(); tick();
    fetch(16'hC840, 0);
    tick(); tick();
    check("bz_not_taken", {24'd0, imem_addr}, 32'h42);

    // JMP 0x10
    fetch(16'hC010, 0);
    tick(); tick();
    check("jmp_addr", {24'd0, imem_addr}, 32'h10);
    exp_pc = 8'h10;

    // ST [R2],R3 then LD R4,[R2]
    fetch(16'h884C, 0);
    check("st_rs", {29'd0, rs_addr}, 32'd2);
    check("st_rt", {29'd0, rt_addr}, 32'd3);
    tick();
    check("st_ex_mw", {31'd0, mem_write}, 32'd0);
    tick();
    check("st_wb", {30'd0, mem_write, rf_write}, 32'd2);
    tick();
    check("st_post_mw", {31'd0, mem_write}, 32'd0);
    fetch(16'h8440, 0);
    check("ld_rd", {29'd0, rd_addr}, 32'd4);
    check("ld_rs", {29'd0, rs_addr}, 32'd2);
    tick(); tick();
    check("ld_wb", {29'd0, rf_write, mem_sel, mem_write}, 32'd6);
    tick();
    check("ld_post_addr", {24'd0, imem_addr}, 32'h12);

    // illegal opcode 10111, then HALT and restart
    fetch(16'hB800, 0);
    check("ill_pulse", {31'd0, illegal_op}, 32'd1);
    tick();
    check("ill_ex", {31'd0, illegal_op}, 32'd0);
    tick();
    check("ill_wb_en", {29'd0, rf_write, mem_write, mem_sel}, 32'd0);
    tick();
    fetch(16'hF800, 0);
    check("halt_de_ill", {31'd0, illegal_op}, 32'd0);
    tick(); tick();
    check("halted", {31'd0, halted}, 32'd1);
    check("halt_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("halt_hold", {30'd0, halted, imem_req}, 32'd2);
    start = 1'b1; tick(); start = 1'b0;
    check("restart_halted", {31'd0, halted}, 32'd0);
    exp_pc = 8'h00;

    // ADD R5,R1,R2 interrupted by reset in EXECUTE
    fetch(16'h0D28, 0);
    tick();
    check("add_alu", {28'd0, alu_sel}, 32'd1);
    reset = 1'b0;
    #1;
    check("abort_outs", {imem_req, rd_addr, alu_sel, rf_write, mem_write, halted}, 32'd0);
    tick(); tick();
    check("abort_wr", {31'd0, rf_write}, 32'd0);
    reset = 1'b1;
    tick(); tick(); tick();
    check("post_rst_idle", {30'd0, imem_req, rf_write}, 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    check("post_rst_fetch", {23'd0, imem_req, imem_addr}, 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
